// File: rtl/uart_flash_pkg.sv
// Shared types and constants for the uart_flash receive path.
package uart_flash_pkg;

  // Width of every byte moved between the UART and the frame RAM.
  localparam int unsigned ByteWidth = 8;

  // Idle sclk cycles tolerated between payload bytes.
  localparam int unsigned TimeoutCyclesDefault = 50000;

  typedef logic [ByteWidth-1:0] byte_t;

  // Frame reception FSM states.
  typedef enum logic [2:0] {
    StIdle,
    StWaitLen,
    StRecv,
    StDone,
    StTimeout
  } state_e;

endpackage

// File: rtl/write_ram_addr_gen_if.sv
// Bus between the UART receiver / controller FSM and the RAM write generator.
interface write_ram_addr_gen_if
  import uart_flash_pkg::*;
;

  // Control and receive side.
  logic  enable;
  logic  rxValid;
  byte_t rxData;

  // RAM write side and status.
  logic  ramWe;
  byte_t ramAddress;
  byte_t ramData;
  byte_t dataLength;
  logic  busy;
  logic  finishFlag;
  logic  timeoutFlag;

  // Seen from the address generator.
  modport slave (
    input  enable,
    input  rxValid,
    input  rxData,
    output ramWe,
    output ramAddress,
    output ramData,
    output dataLength,
    output busy,
    output finishFlag,
    output timeoutFlag
  );

  // Seen from whoever drives the generator.
  modport master (
    output enable,
    output rxValid,
    output rxData,
    input  ramWe,
    input  ramAddress,
    input  ramData,
    input  dataLength,
    input  busy,
    input  finishFlag,
    input  timeoutFlag
  );

endinterface

// File: rtl/rx_timeout_timer.sv
// Inter-byte idle timer. Counts while run_i is high, saturates at the last
// count, and flags expiry once TIMEOUT_CYCLES-1 idle cycles have elapsed.
module rx_timeout_timer
  import uart_flash_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TimeoutCyclesDefault
) (
  input  logic sclk,
  input  logic srst,
  input  logic clear_i,
  input  logic run_i,
  output logic expired_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Next count: clear has priority, otherwise count up and hold at the last value.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (run_i && (cnt_q != LastCnt)) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge sclk or posedge srst) begin
    if (srst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The FSM acts on this at the edge that would make the idle time TIMEOUT_CYCLES.
  assign expired_o = (cnt_q == LastCnt);

endmodule

// File: rtl/write_ram_addr_gen.sv
// Receives a length-prefixed frame from the UART and writes the payload into
// the frame RAM from address 0 upward, reporting finish or timeout status.
module write_ram_addr_gen
  import uart_flash_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TimeoutCyclesDefault
) (
  input logic                 sclk,
  input logic                 srst,
  write_ram_addr_gen_if.slave bus
);

  state_e state_q;
  byte_t  count_q;
  logic   ram_we_q;
  byte_t  ram_address_q;
  byte_t  ram_data_q;
  byte_t  data_length_q;
  logic   busy_q;
  logic   finish_q;
  logic   timeout_q;

  logic tmr_clear;
  logic tmr_run;
  logic tmr_expired;

  // The timer only runs in RECV; any accepted byte restarts the idle window.
  assign tmr_run   = (state_q == StRecv);
  assign tmr_clear = (state_q != StRecv) || bus.rxValid;

  rx_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .sclk     (sclk),
    .srst     (srst),
    .clear_i  (tmr_clear),
    .run_i    (tmr_run),
    .expired_o(tmr_expired)
  );

  // Frame FSM with all outputs registered alongside the state.
  always_ff @(posedge sclk or posedge srst) begin
    if (srst) begin
      state_q       <= StIdle;
      count_q       <= '0;
      ram_we_q      <= 1'b0;
      ram_address_q <= '0;
      ram_data_q    <= '0;
      data_length_q <= '0;
      busy_q        <= 1'b0;
      finish_q      <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      // Write strobe is a single-cycle pulse; address/data hold otherwise.
      ram_we_q <= 1'b0;
      unique case (state_q)
        // Arming is only honoured when no frame is in progress.
        StIdle, StDone, StTimeout: begin
          if (bus.enable) begin
            state_q       <= StWaitLen;
            count_q       <= '0;
            data_length_q <= '0;
            busy_q        <= 1'b1;
            finish_q      <= 1'b0;
            timeout_q     <= 1'b0;
          end
        end
        StWaitLen: begin
          if (bus.rxValid) begin
            data_length_q <= bus.rxData;
            if (bus.rxData == '0) begin
              state_q  <= StDone;
              busy_q   <= 1'b0;
              finish_q <= 1'b1;
            end else begin
              state_q <= StRecv;
              count_q <= '0;
            end
          end
        end
        StRecv: begin
          // A byte arriving on the expiry cycle takes priority over the timeout.
          if (bus.rxValid) begin
            ram_we_q      <= 1'b1;
            ram_address_q <= count_q;
            ram_data_q    <= bus.rxData;
            count_q       <= count_q + byte_t'(1);
            if (count_q == data_length_q - byte_t'(1)) begin
              state_q  <= StDone;
              busy_q   <= 1'b0;
              finish_q <= 1'b1;
            end
          end else if (tmr_expired) begin
            state_q   <= StTimeout;
            busy_q    <= 1'b0;
            timeout_q <= 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ramWe       = ram_we_q;
  assign bus.ramAddress  = ram_address_q;
  assign bus.ramData     = ram_data_q;
  assign bus.dataLength  = data_length_q;
  assign bus.busy        = busy_q;
  assign bus.finishFlag  = finish_q;
  assign bus.timeoutFlag = timeout_q;

endmodule
